// File: rtl/noc_pkg.sv
// Shared NoC definitions: default link sizing, tx FSM state encodings and a
// constant-evaluable clog2 used to size credit arithmetic.
package noc_pkg;

  localparam int NOC_NUM_BITS = 8;
  localparam int NOC_DEPTH    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Up/down credit counter saturating at DEPTH, with a sticky overflow flag for
// credits returned when every downstream slot is already free.
module noc_credit_counter
  import noc_pkg::*;
#(
  parameter int DEPTH = NOC_DEPTH,
  parameter int CW    = clog2(NOC_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          err
);

  localparam logic [CW-1:0] MAX = CW'(DEPTH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case ({inc, dec})
      2'b10: begin
        if (cnt_q == MAX) err_d = 1'b1;
        else              cnt_d = cnt_q + 1'b1;
      end
      // dec is only issued with a nonzero count; the guard keeps it from wrapping
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= MAX;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt = cnt_q;
  assign err = err_q;

endmodule

// File: rtl/flit_link_tx.sv
// Link transmitter: pops the local port FIFO under credit flow control and
// registers flits onto the link. Optional LINK_TX_PARITY_EN adds link_parity.
module flit_link_tx
  import noc_pkg::*;
#(
  parameter int NUM_BITS = NOC_NUM_BITS,
  parameter int DEPTH    = NOC_DEPTH,
  localparam int CW      = clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tx_en,
  input  logic                fifo_empty,
  input  logic [NUM_BITS-1:0] fifo_out,
  output logic                fifo_rd_en,
  input  logic                credit_in,
  output logic                link_valid,
  output logic [NUM_BITS-1:0] link_data,
  output logic [CW-1:0]       credit_cnt,
  output logic                busy,
  output logic                credit_err
`ifdef LINK_TX_PARITY_EN
  ,
  output logic                link_parity
`endif
);

  tx_state_e state_q, state_d;

  // vld_pipe[1]: pop issued last cycle, FIFO data valid now; vld_pipe[2]: flit on link
  logic [2:1]          vld_pipe_q, vld_pipe_d;
  logic [NUM_BITS-1:0] link_data_q, link_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (tx_en) state_d = ST_RUN;
      ST_RUN:   if (!tx_en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (tx_en)                 state_d = ST_RUN;
        else if (vld_pipe_q == '0) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = (state_q == ST_RUN) && !fifo_empty && (credit_cnt != '0);
  end

  always_comb begin
    vld_pipe_d  = {vld_pipe_q[1], fifo_rd_en};
    link_data_d = vld_pipe_q[1] ? fifo_out : link_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      link_data_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      link_data_q <= link_data_d;
    end
  end

`ifdef LINK_TX_PARITY_EN
  logic link_parity_q, link_parity_d;

  always_comb link_parity_d = vld_pipe_q[1] ? ^fifo_out : link_parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) link_parity_q <= 1'b0;
    else        link_parity_q <= link_parity_d;
  end

  assign link_parity = link_parity_q;
`endif

  noc_credit_counter #(.DEPTH(DEPTH), .CW(CW)) u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .dec   (fifo_rd_en),
    .inc   (credit_in),
    .cnt   (credit_cnt),
    .err   (credit_err)
  );

  assign link_valid = vld_pipe_q[2];
  assign link_data  = link_data_q;
  assign busy       = vld_pipe_q[1] | vld_pipe_q[2] | fifo_rd_en;

endmodule

// File: tb/tb_flit_link_tx.sv
// Directed bench for flit_link_tx: behavioural port FIFO, link monitor and
// hand-computed expectations. Build with LINK_TX_PARITY_EN to cover parity.
module tb_flit_link_tx;
  import noc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_out = 8'h00;
  logic       fifo_rd_en;
  logic       credit_in = 1'b0;
  logic       link_valid;
  logic [7:0] link_data;
  logic [3:0] credit_cnt;
  logic       busy;
  logic       credit_err;
`ifdef LINK_TX_PARITY_EN
  logic       link_parity;
`endif

  flit_link_tx #(.NUM_BITS(8), .DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_out   (fifo_out),
    .fifo_rd_en (fifo_rd_en),
    .credit_in  (credit_in),
    .link_valid (link_valid),
    .link_data  (link_data),
    .credit_cnt (credit_cnt),
    .busy       (busy),
    .credit_err (credit_err)
`ifdef LINK_TX_PARITY_EN
    ,
    .link_parity(link_parity)
`endif
  );

  always #5 clk = ~clk;

  // port FIFO model: data valid the cycle after the pop
  logic [7:0] mem [0:255];
  logic [7:0] wp = 8'd0, rp = 8'd0;
  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_out <= mem[rp];
      rp       <= rp + 8'd1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // link monitor
  logic [7:0] rx_data [0:63];
  int         rx_cyc  [0:63];
  int         rx_n = 0, n_pops = 0, first_rd = -1;
  bit         seen_drain = 1'b0;

  always @(negedge clk) begin
    if (fifo_rd_en) begin
      if (first_rd < 0) first_rd = cyc;
      n_pops = n_pops + 1;
    end
    if (link_valid && rx_n < 64) begin
      rx_data[rx_n] = link_data;
      rx_cyc[rx_n]  = cyc;
      rx_n = rx_n + 1;
    end
    if (dut.state_q == ST_DRAIN) seen_drain = 1'b1;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wp] = v;
    wp = wp + 8'd1;
  endtask

  task automatic clr_log();
    rx_n = 0; n_pops = 0; first_rd = -1; seen_drain = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tx_en = 1'b0; credit_in = 1'b0;
    wp = rp;
    step(2);
    rst_n = 1'b1;
    clr_log();
  endtask

  task automatic wait_rd(input string tag);
    int k;
    k = 0;
    while (!fifo_rd_en && k < 10) begin
      step(1);
      k++;
    end
    chk(tag, int'(fifo_rd_en), 1);
  endtask

  int c0;

  initial begin
    // reset values
    step(1);
    chk("rst_cnt",   int'(credit_cnt), 8);
    chk("rst_valid", int'(link_valid), 0);
    chk("rst_data",  int'(link_data),  0);
    chk("rst_busy",  int'(busy),       0);
    chk("rst_err",   int'(credit_err), 0);

    // 1: three preloaded flits stream back to back
    do_reset();
    push(8'h11); push(8'h22); push(8'h33);
    tx_en = 1'b1;
    step(10);
    chk("t1_n",     rx_n, 3);
    chk("t1_d0",    int'(rx_data[0]), 'h11);
    chk("t1_d1",    int'(rx_data[1]), 'h22);
    chk("t1_d2",    int'(rx_data[2]), 'h33);
    chk("t1_lat",   rx_cyc[0], first_rd + 2);
    chk("t1_b2b1",  rx_cyc[1], rx_cyc[0] + 1);
    chk("t1_b2b2",  rx_cyc[2], rx_cyc[0] + 2);
    chk("t1_cnt",   int'(credit_cnt), 5);
    chk("t1_hold",  int'(link_data), 'h33);

    // 2: credits exhaust after DEPTH flits; one credit releases the 9th
    do_reset();
    for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
    tx_en = 1'b1;
    step(20);
    chk("t2_n",     rx_n, 8);
    chk("t2_d7",    int'(rx_data[7]), 'hA7);
    chk("t2_cnt0",  int'(credit_cnt), 0);
    chk("t2_block", int'(fifo_rd_en), 0);
    chk("t2_idle",  int'(busy), 0);
    clr_log();
    c0 = cyc;
    credit_in = 1'b1;
    step(1);
    credit_in = 1'b0;
    step(6);
    chk("t2_n9",    rx_n, 1);
    chk("t2_d9",    int'(rx_data[0]), 'hA8);
    chk("t2_lat9",  rx_cyc[0], c0 + 3);

    // 3: pop and credit return together leave the count unchanged
    do_reset();
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    tx_en = 1'b1;
    step(8);
    chk("t3_cnt4",  int'(credit_cnt), 4);
    push(8'h5A);
    credit_in = 1'b1;
    #1;
    chk("t3_rd",    int'(fifo_rd_en), 1);
    step(1);
    credit_in = 1'b0;
    chk("t3_same",  int'(credit_cnt), 4);
    credit_in = 1'b1;
    step(1);
    credit_in = 1'b0;
    chk("t3_inc",   int'(credit_cnt), 5);

    // 4: credit returned with a full count saturates and flags an error
    do_reset();
    credit_in = 1'b1;
    step(1);
    credit_in = 1'b0;
    chk("t4_cnt",   int'(credit_cnt), 8);
    chk("t4_err",   int'(credit_err), 1);
    step(5);
    chk("t4_stick", int'(credit_err), 1);
    rst_n = 1'b0;
    #1;
    chk("t4_clr",   int'(credit_err), 0);

    // 5: tx_en drops during the first pop; in-flight flit still delivered
    do_reset();
    push(8'h61); push(8'h62); push(8'h63);
    tx_en = 1'b1;
    wait_rd("t5_rd");
    chk("t5_busy",  int'(busy), 1);
    tx_en = 1'b0;
    step(10);
    chk("t5_n",     rx_n, 1);
    chk("t5_d",     int'(rx_data[0]), 'h61);
    chk("t5_pops",  n_pops, 1);
    chk("t5_drain", int'(seen_drain), 1);
    chk("t5_idle",  int'(dut.state_q), int'(ST_IDLE));
    chk("t5_busy0", int'(busy), 0);
    chk("t5_cnt",   int'(credit_cnt), 7);

    // 6: reset with two flits in flight discards both
    do_reset();
    for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
    tx_en = 1'b1;
    wait_rd("t6_rd");
    step(2);
    rst_n = 1'b0;
    tx_en = 1'b0;
    #1;
    clr_log();
    chk("t6_valid", int'(link_valid), 0);
    chk("t6_cnt",   int'(credit_cnt), 8);
    step(2);
    rst_n = 1'b1;
    step(6);
    chk("t6_none",  rx_n, 0);

`ifdef LINK_TX_PARITY_EN
    do_reset();
    push(8'h07);
    tx_en = 1'b1;
    step(6);
    chk("par_d",    int'(link_data), 'h07);
    chk("par_1",    int'(link_parity), 1);
    push(8'h03);
    step(6);
    chk("par_0",    int'(link_parity), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
